// File: rtl/digit_cursor.sv
// Digit-select cursor for the time/alarm set screens: left/right stepping with wrap or
// saturate, hold auto-repeat, one-hot select and blinking mask for the 7-seg driver.
module digit_cursor #(
   parameter int NUM_DIGITS  = 8,
   parameter int WRAP        = 1,
   parameter int REPEAT_DLY  = 50,
   parameter int REPEAT_RATE = 10,
   parameter int BLINK_DIV   = 25,
   localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                  digit_cursor_clk,
   input  logic                  digit_cursor_rst,
   input  logic                  digit_cursor_en,
   input  logic                  digit_cursor_left,
   input  logic                  digit_cursor_right,
   input  logic                  digit_cursor_home,
   output logic [IW-1:0]         digit_cursor_idx,
   output logic [NUM_DIGITS-1:0] digit_cursor_sel,
   output logic [NUM_DIGITS-1:0] digit_cursor_blink,
   output logic                  digit_cursor_moved
);

   localparam int HW = $clog2(REPEAT_DLY + REPEAT_RATE + 1);
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [IW-1:0]         r_idx;
   logic [IW-1:0]         w_idx_nxt;
   logic                  r_moved;
   logic                  r_prev_l;
   logic                  r_prev_r;
   logic                  r_lock;
   logic                  r_hidden;
   logic                  w_hidden_nxt;
   logic [HW-1:0]         r_hold_cnt;
   logic [HW-1:0]         w_hold_nxt;
   logic [BW-1:0]         r_blink_cnt;
   logic [BW-1:0]         w_blink_nxt;
   logic                  w_held_l;
   logic                  w_held_r;
   logic                  w_edge;
   logic                  w_repeat;
   logic [NUM_DIGITS-1:0] w_one;
   logic [NUM_DIGITS-1:0] w_sel;

   function automatic logic [IW-1:0] step_idx(input logic [IW-1:0] idx, input logic go_left);
      logic [IW-1:0] res;
      if (go_left) begin
         if (idx == IW'(NUM_DIGITS - 1)) res = (WRAP != 0) ? IW'(0) : idx;
         else                            res = idx + IW'(1);
      end else begin
         if (idx == IW'(0)) res = (WRAP != 0) ? IW'(NUM_DIGITS - 1) : IW'(0);
         else               res = idx - IW'(1);
      end
      return res;
   endfunction

   // Both buttons high counts as neither held, so releasing one yields a fresh edge.
   assign w_held_l = digit_cursor_left & ~digit_cursor_right;
   assign w_held_r = digit_cursor_right & ~digit_cursor_left;
   assign w_edge   = ~r_lock & ((w_held_l & ~r_prev_l) | (w_held_r & ~r_prev_r));
   // Hold count is 0 when unarmed; it wraps from DLY+RATE back to DLY+1 so it never overflows.
   assign w_repeat = (REPEAT_DLY != 0) && (r_hold_cnt != HW'(0)) && (w_held_l | w_held_r) &&
                     ((r_hold_cnt == HW'(REPEAT_DLY)) || (r_hold_cnt == HW'(REPEAT_DLY + REPEAT_RATE)));

   // Cursor step, hold-repeat counter and blink phase next-state.
   always_comb begin
      w_idx_nxt    = r_idx;
      w_hold_nxt   = HW'(0);
      w_blink_nxt  = BW'(0);
      w_hidden_nxt = 1'b0;
      if (!digit_cursor_en) begin
         w_hold_nxt = HW'(0);
      end else if (digit_cursor_home) begin
         w_idx_nxt  = IW'(0);
         w_hold_nxt = HW'(0);
      end else if (w_edge) begin
         w_idx_nxt  = step_idx(r_idx, w_held_l);
         w_hold_nxt = HW'(1);
      end else if ((w_held_l | w_held_r) && (r_hold_cnt != HW'(0))) begin
         if (w_repeat) w_idx_nxt = step_idx(r_idx, w_held_l);
         else          w_idx_nxt = r_idx;
         if (r_hold_cnt == HW'(REPEAT_DLY + REPEAT_RATE)) w_hold_nxt = HW'(REPEAT_DLY + 1);
         else if (REPEAT_DLY == 0)                        w_hold_nxt = r_hold_cnt;
         else                                             w_hold_nxt = r_hold_cnt + HW'(1);
      end else begin
         w_hold_nxt = HW'(0);
      end

      if (!digit_cursor_en) begin
         w_blink_nxt  = BW'(0);
         w_hidden_nxt = 1'b0;
      end else if (w_idx_nxt != r_idx) begin
         w_blink_nxt  = BW'(0);
         w_hidden_nxt = 1'b0;
      end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
         w_blink_nxt  = BW'(0);
         w_hidden_nxt = ~r_hidden;
      end else begin
         w_blink_nxt  = r_blink_cnt + BW'(1);
         w_hidden_nxt = r_hidden;
      end
   end

   // State registers; a button held through reset stays locked out until released.
   always_ff @(posedge digit_cursor_clk) begin
      if (digit_cursor_rst) begin
         r_idx       <= IW'(0);
         r_moved     <= 1'b0;
         r_prev_l    <= 1'b0;
         r_prev_r    <= 1'b0;
         r_lock      <= digit_cursor_left | digit_cursor_right;
         r_hold_cnt  <= HW'(0);
         r_blink_cnt <= BW'(0);
         r_hidden    <= 1'b0;
      end else begin
         r_idx       <= w_idx_nxt;
         r_moved     <= (w_idx_nxt != r_idx);
         r_prev_l    <= w_held_l;
         r_prev_r    <= w_held_r;
         r_lock      <= r_lock & (digit_cursor_left | digit_cursor_right);
         r_hold_cnt  <= w_hold_nxt;
         r_blink_cnt <= w_blink_nxt;
         r_hidden    <= w_hidden_nxt;
      end
   end

   assign w_one = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
   assign w_sel = (digit_cursor_en & ~digit_cursor_rst) ? (w_one << r_idx) : {NUM_DIGITS{1'b0}};

   assign digit_cursor_idx   = r_idx;
   assign digit_cursor_moved = r_moved;
   assign digit_cursor_sel   = w_sel;
   assign digit_cursor_blink = r_hidden ? {NUM_DIGITS{1'b0}} : w_sel;

endmodule

// File: tb/tb_digit_cursor.sv
// Scenario bench for digit_cursor: wrap and saturate instances, expected cursor values
// are queued as stimulus is driven and compared after each clock edge.
module tb_digit_cursor;

   logic       clk = 1'b0;
   logic       rst, en, en_s, left, right, home;
   logic [2:0] idx, idx_s;
   logic [5:0] sel, blink, sel_s, blink_s;
   logic       moved, moved_s;

   typedef struct {int idx; bit moved;} exp_t;
   exp_t q[$];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   digit_cursor #(.NUM_DIGITS(6), .WRAP(1), .REPEAT_DLY(4), .REPEAT_RATE(2), .BLINK_DIV(3)) dut (
      .digit_cursor_clk(clk), .digit_cursor_rst(rst), .digit_cursor_en(en),
      .digit_cursor_left(left), .digit_cursor_right(right), .digit_cursor_home(home),
      .digit_cursor_idx(idx), .digit_cursor_sel(sel), .digit_cursor_blink(blink),
      .digit_cursor_moved(moved));

   digit_cursor #(.NUM_DIGITS(6), .WRAP(0), .REPEAT_DLY(4), .REPEAT_RATE(2), .BLINK_DIV(3)) dut_sat (
      .digit_cursor_clk(clk), .digit_cursor_rst(rst), .digit_cursor_en(en_s),
      .digit_cursor_left(left), .digit_cursor_right(right), .digit_cursor_home(home),
      .digit_cursor_idx(idx_s), .digit_cursor_sel(sel_s), .digit_cursor_blink(blink_s),
      .digit_cursor_moved(moved_s));

   // queue the expectation for the coming edge, then move to the sampling (falling) edge
   task automatic tick(input int ei, input bit em);
      q.push_back('{ei, em});
      @(negedge clk);
   endtask

   task automatic test_reset;
      exp_t e;
      rst = 1'b1; en = 1'b1; en_s = 1'b0; left = 1'b0; right = 1'b0; home = 1'b0;
      @(negedge clk);
      tick(0, 1'b0);
      e = q.pop_front();
      total++; if (idx !== 3'(e.idx)) begin bad++; $display("FAIL reset_idx got=%0d want=%0d", idx, e.idx); end
      total++; if (moved !== e.moved) begin bad++; $display("FAIL reset_moved got=%0b want=%0b", moved, e.moved); end
      total++; if (sel !== 6'b000000) begin bad++; $display("FAIL reset_sel got=%b want=000000", sel); end
      total++; if (blink !== 6'b000000) begin bad++; $display("FAIL reset_blink got=%b want=000000", blink); end
      rst = 1'b0;
      tick(0, 1'b0);
      e = q.pop_front();
      total++; if (idx !== 3'(e.idx)) begin bad++; $display("FAIL post_reset_idx got=%0d want=%0d", idx, e.idx); end
      total++; if (sel !== 6'b000001) begin bad++; $display("FAIL post_reset_sel got=%b want=000001", sel); end
      total++; if (blink !== 6'b000001) begin bad++; $display("FAIL post_reset_blink got=%b want=000001", blink); end
   endtask

   task automatic test_pulse_left;
      exp_t e;
      for (int i = 1; i <= 3; i++) begin
         for (int ph = 0; ph < 2; ph++) begin
            left = (ph == 0);
            tick(i, ph == 0);
            e = q.pop_front();
            total++; if (idx !== 3'(e.idx)) begin bad++; $display("FAIL pulse_idx got=%0d want=%0d", idx, e.idx); end
            total++; if (moved !== e.moved) begin bad++; $display("FAIL pulse_moved got=%0b want=%0b", moved, e.moved); end
         end
      end
      total++; if (sel !== 6'b001000) begin bad++; $display("FAIL pulse_sel got=%b want=001000", sel); end
   endtask

   task automatic test_wrap;
      exp_t e;
      int   ei[4] = '{4, 5, 0, 5};
      bit   lf[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int p = 0; p < 4; p++) begin
         for (int ph = 0; ph < 2; ph++) begin
            left  = (ph == 0) && lf[p];
            right = (ph == 0) && !lf[p];
            tick(ei[p], ph == 0);
            e = q.pop_front();
            total++; if (idx !== 3'(e.idx)) begin bad++; $display("FAIL wrap_idx got=%0d want=%0d", idx, e.idx); end
            total++; if (moved !== e.moved) begin bad++; $display("FAIL wrap_moved got=%0b want=%0b", moved, e.moved); end
         end
      end
   endtask

   task automatic test_saturate;
      exp_t e;
      int   ei[8] = '{0, 1, 2, 3, 4, 5, 5, 4};
      bit   em[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      en = 1'b0; en_s = 1'b1;
      for (int p = 0; p < 8; p++) begin
         for (int ph = 0; ph < 2; ph++) begin
            left  = (ph == 0) && (p >= 1) && (p <= 6);
            right = (ph == 0) && ((p == 0) || (p == 7));
            tick(ei[p], (ph == 0) && em[p]);
            e = q.pop_front();
            total++; if (idx_s !== 3'(e.idx)) begin bad++; $display("FAIL sat_idx got=%0d want=%0d", idx_s, e.idx); end
            total++; if (moved_s !== e.moved) begin bad++; $display("FAIL sat_moved got=%0b want=%0b", moved_s, e.moved); end
         end
      end
      total++; if (idx !== 3'd5) begin bad++; $display("FAIL disabled_idx got=%0d want=5", idx); end
      total++; if (sel !== 6'b000000) begin bad++; $display("FAIL disabled_sel got=%b want=000000", sel); end
      en_s = 1'b0; en = 1'b1;
   endtask

   task automatic test_hold;
      exp_t e;
      int   ei[12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
      home = 1'b1;
      tick(0, 1'b1);
      e = q.pop_front();
      total++; if (idx !== 3'(e.idx)) begin bad++; $display("FAIL home_idx got=%0d want=%0d", idx, e.idx); end
      total++; if (moved !== e.moved) begin bad++; $display("FAIL home_moved got=%0b want=%0b", moved, e.moved); end
      home = 1'b0;
      left = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick(ei[i], (i == 0) || (ei[i] != ei[(i == 0) ? 0 : i - 1]));
         e = q.pop_front();
         total++; if (idx !== 3'(e.idx)) begin bad++; $display("FAIL hold_idx k=%0d got=%0d want=%0d", i, idx, e.idx); end
         total++; if (moved !== e.moved) begin bad++; $display("FAIL hold_moved k=%0d got=%0b want=%0b", i, moved, e.moved); end
      end
      left = 1'b0;
      tick(5, 1'b0);
      e = q.pop_front();
      total++; if (idx !== 3'(e.idx)) begin bad++; $display("FAIL hold_release_idx got=%0d want=%0d", idx, e.idx); end
   endtask

   task automatic test_both;
      exp_t e;
      left = 1'b1; right = 1'b1;
      for (int i = 0; i < 11; i++) begin
         if (i == 10) right = 1'b0;
         tick((i == 10) ? 0 : 5, i == 10);
         e = q.pop_front();
         total++; if (idx !== 3'(e.idx)) begin bad++; $display("FAIL both_idx c=%0d got=%0d want=%0d", i, idx, e.idx); end
         total++; if (moved !== e.moved) begin bad++; $display("FAIL both_moved c=%0d got=%0b want=%0b", i, moved, e.moved); end
      end
      left = 1'b0;
      tick(0, 1'b0);
      e = q.pop_front();
      total++; if (idx !== 3'(e.idx)) begin bad++; $display("FAIL both_release_idx got=%0d want=%0d", idx, e.idx); end
   endtask

   task automatic test_blink;
      exp_t       e;
      logic [5:0] want;
      right = 1'b1;
      for (int j = 0; j <= 10; j++) begin
         tick(5, j == 0);
         right = 1'b0;
         e = q.pop_front();
         want = (((j / 3) % 2) == 0) ? 6'b100000 : 6'b000000;
         total++; if (idx !== 3'(e.idx)) begin bad++; $display("FAIL blink_idx j=%0d got=%0d want=%0d", j, idx, e.idx); end
         total++; if (blink !== want) begin bad++; $display("FAIL blink_mask j=%0d got=%b want=%b", j, blink, want); end
      end
      left = 1'b1;
      tick(0, 1'b1);
      left = 1'b0;
      e = q.pop_front();
      total++; if (idx !== 3'(e.idx)) begin bad++; $display("FAIL blink_step_idx got=%0d want=%0d", idx, e.idx); end
      total++; if (blink !== 6'b000001) begin bad++; $display("FAIL blink_restart got=%b want=000001", blink); end
      tick(0, 1'b0);
      void'(q.pop_front());
   endtask

   task automatic test_reset_hold;
      exp_t e;
      right = 1'b1;
      for (int c = 0; c < 17; c++) begin
         rst = (c == 3);
         if (c == 14) right = 1'b0;
         if (c == 15) right = 1'b1;
         if (c == 16) right = 1'b0;
         tick(((c < 3) || (c >= 15)) ? 5 : 0, (c == 0) || (c == 15));
         e = q.pop_front();
         total++; if (idx !== 3'(e.idx)) begin bad++; $display("FAIL rsthold_idx c=%0d got=%0d want=%0d", c, idx, e.idx); end
         total++; if (moved !== e.moved) begin bad++; $display("FAIL rsthold_moved c=%0d got=%0b want=%0b", c, moved, e.moved); end
         if (c == 3) begin
            total++; if (sel !== 6'b000000) begin bad++; $display("FAIL rsthold_sel got=%b want=000000", sel); end
            total++; if (blink !== 6'b000000) begin bad++; $display("FAIL rsthold_blink got=%b want=000000", blink); end
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   ei[13] = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 0, 5, 5, 5};
      en = 1'b0; left = 1'b1;
      for (int c = 0; c < 13; c++) begin
         if (c == 2) en = 1'b1;
         if (c == 8) left = 1'b0;
         if (c == 9) left = 1'b1;
         if (c == 10) begin left = 1'b0; right = 1'b1; end
         if (c == 11) right = 1'b0;
         tick(ei[c], (c == 9) || (c == 10));
         e = q.pop_front();
         total++; if (idx !== 3'(e.idx)) begin bad++; $display("FAIL b2b_idx c=%0d got=%0d want=%0d", c, idx, e.idx); end
         total++; if (moved !== e.moved) begin bad++; $display("FAIL b2b_moved c=%0d got=%0b want=%0b", c, moved, e.moved); end
         if (c == 1) begin
            total++; if (sel !== 6'b000000) begin bad++; $display("FAIL b2b_sel_off got=%b want=000000", sel); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_pulse_left;
      test_wrap;
      test_saturate;
      test_hold;
      test_both;
      test_blink;
      test_reset_hold;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
